// File: rtl/jtframe_rom_pkg.sv
// Shared definitions for the ROM slot: line width, word-offset helper and
// the fetch state encoding.
package jtframe_rom_pkg;

  // Every SDRAM fetch returns one 32-bit line.
  localparam int LINE_W = 32;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Number of word-select bits inside a line: 2 for byte words, 1 for 16-bit words.
  function automatic int off_of(input int dw);
    return (dw == 16) ? 1 : 2;
  endfunction

endpackage

// File: rtl/jtframe_rom_line.sv
// One cache entry: valid/tag/data registers, a write port, the tag compare
// and the little-endian word select for the current address.
module jtframe_rom_line
  import jtframe_rom_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 8,
  localparam int OFF = off_of(DW),
  localparam int TW  = AW - OFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [TW-1:0]     wtag,
  input  logic [LINE_W-1:0] wdata,
  input  logic [AW-1:0]     addr,
  output logic              hit,
  output logic [DW-1:0]     word
);

  logic              valid;
  logic [TW-1:0]     tag;
  logic [LINE_W-1:0] data;
  logic [OFF-1:0]    sel;

  // Entry storage; clr only drops valid, the stale data stays visible on word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (we) begin
      valid <= 1'b1;
      tag   <= wtag;
      data  <= wdata;
    end
  end

  assign sel = addr[OFF-1:0];
  assign hit = valid && (tag == addr[AW-1:OFF]);

  // Word select, lowest address in the least significant bits of the line.
  always_comb begin
    word = '0;
    for (int i = 0; i < LINE_W / DW; i++) begin
      if (sel == i[OFF-1:0]) word = data[i*DW +: DW];
    end
  end

endmodule

// File: rtl/jtframe_rom_slot.sv
// ROM-side responder: answers CPU reads from a two-entry line cache and
// fetches missing 32-bit lines from one SDRAM slot. ok low stalls the CPU.
// DW must be 8 or 16.
module jtframe_rom_slot
  import jtframe_rom_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cs,
  input  logic [AW-1:0]     addr,
  output logic [DW-1:0]     dout,
  output logic              ok,
  output logic [AW-1:0]     sdram_addr,
  output logic              sdram_req,
  input  logic              sdram_ack,
  input  logic              sdram_dst,
  input  logic              sdram_rdy,
  input  logic [LINE_W-1:0] din
);

  localparam int OFF = off_of(DW);
  localparam int TW  = AW - OFF;

  // SDRAM handshake: sdram_req is registered and held, with sdram_addr
  // stable, until sdram_ack is seen in ST_REQ; afterwards the line arrives
  // on din in the single cycle where sdram_dst && sdram_rdy are both high.
  // rdy strobes outside ST_WAIT or without dst are ignored.

  state_t        state, state_nx;
  logic [TW-1:0] tag_q, tag_nx, cur_tag;
  logic [AW-1:0] saddr_nx;
  logic          req_nx;
  logic          victim, victim_nx;
  logic          discard, discard_nx;
  logic          fill, write, any_hit;
  logic          hit0, hit1;
  logic [DW-1:0] word0, word1;

  assign cur_tag = addr[AW-1:OFF];
  assign any_hit = hit0 || hit1;
  assign fill    = (state == ST_WAIT) && sdram_dst && sdram_rdy;
  // A clr in the same cycle as the data strobe also suppresses the write.
  assign write   = fill && !discard && !clr;

  jtframe_rom_line #(.AW(AW), .DW(DW)) u_line0 (
    .clk(clk), .rst(rst), .clr(clr), .we(write && !victim),
    .wtag(tag_q), .wdata(din), .addr(addr), .hit(hit0), .word(word0)
  );

  jtframe_rom_line #(.AW(AW), .DW(DW)) u_line1 (
    .clk(clk), .rst(rst), .clr(clr), .we(write && victim),
    .wtag(tag_q), .wdata(din), .addr(addr), .hit(hit1), .word(word1)
  );

  // Hits answer in the same cycle; entry 0 drives dout when nothing hits.
  assign ok   = cs && any_hit;
  assign dout = (hit1 && !hit0) ? word1 : word0;

  // Fetch sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tag_q      <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      victim     <= 1'b0;
      discard    <= 1'b0;
    end else begin
      state      <= state_nx;
      tag_q      <= tag_nx;
      sdram_req  <= req_nx;
      sdram_addr <= saddr_nx;
      victim     <= victim_nx;
      discard    <= discard_nx;
    end
  end

  // Next state: a miss is only evaluated in ST_IDLE; an started fetch always
  // runs to completion even if cs drops or addr moves.
  always_comb begin
    state_nx   = state;
    tag_nx     = tag_q;
    req_nx     = sdram_req;
    saddr_nx   = sdram_addr;
    victim_nx  = victim;
    discard_nx = discard;
    case (state)
      ST_IDLE: begin
        if (cs && !any_hit) begin
          tag_nx   = cur_tag;
          saddr_nx = {cur_tag, {OFF{1'b0}}};
          req_nx   = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_nx   = 1'b0;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fill) begin
          state_nx = ST_IDLE;
          if (write) victim_nx = ~victim;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        req_nx   = 1'b0;
      end
    endcase
    // A clr while a fetch is outstanding makes that fetch land nowhere.
    if (state_nx == ST_IDLE) discard_nx = 1'b0;
    else if (clr && state != ST_IDLE) discard_nx = 1'b1;
  end

endmodule

// File: tb/tb_jtframe_rom_slot.sv
// Bench for jtframe_rom_slot: a directed vector table, hand-written corner
// sequences and a randomized run against a line-cache reference model.
module tb_jtframe_rom_slot;
  localparam int AW = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, clr, cs;
  logic [AW-1:0] addr;
  logic sdram_ack, sdram_dst, sdram_rdy;
  logic [31:0] din;

  logic [7:0]    dout8;
  logic          ok8, req8;
  logic [AW-1:0] saddr8;
  logic [15:0]   dout16;
  logic          ok16, req16;
  logic [AW-1:0] saddr16;

  always #5 clk = ~clk;

  jtframe_rom_slot #(.AW(AW), .DW(8)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .cs(cs), .addr(addr),
    .dout(dout8), .ok(ok8), .sdram_addr(saddr8), .sdram_req(req8),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_rdy(sdram_rdy), .din(din)
  );

  jtframe_rom_slot #(.AW(AW), .DW(16)) dut16 (
    .clk(clk), .rst(rst), .clr(clr), .cs(cs), .addr(addr),
    .dout(dout16), .ok(ok16), .sdram_addr(saddr16), .sdram_req(req16),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst), .sdram_rdy(sdram_rdy), .din(din)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_rdy = 1'b0; din = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b0; addr = '0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Miss on a, wait for req, ack, deliver d; returns one cycle after rdy.
  task automatic fetch8(input logic [AW-1:0] a, input logic [31:0] d);
    int n;
    cs = 1'b1; addr = a;
    idle_inputs();
    step();
    n = 0;
    while (!req8 && n < 8) begin
      step();
      n++;
    end
    check("fetch_req", req8, 1'b1);
    check("fetch_saddr", saddr8, {a[AW-1:2], 2'b00});
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_rdy = 1'b1; din = d;
    step();
    sdram_dst = 1'b0; sdram_rdy = 1'b0; din = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          cs;
    logic [AW-1:0] addr;
    logic          ack;
    logic          rdy;
    logic [31:0]   din;
    logic          exp_ok;
    logic [7:0]    exp_dout;
    logic          exp_req;
    logic [AW-1:0] exp_saddr;
  } vec_t;

  vec_t tbl[15];

  // ---------------- reference model for the random run ----------------
  logic          m_valid[2];
  logic [AW-3:0] m_tag[2];
  logic [31:0]   m_data[2];
  logic          m_vic, m_busy, m_discard, m_req;
  logic [AW-3:0] m_fill_tag;
  int            bases[6];

  initial begin
    int c_st, c_cnt;
    logic fill_now, was_busy, prev_req, h0, h1;
    logic [7:0] e_dout;
    logic [31:0] wd;

    // cold miss, 3-cycle ack wait, hit on both words, second line into entry 1
    tbl[0]  = '{1'b1, 18'h10, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 18'h0};
    tbl[1]  = '{1'b1, 18'h10, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 18'h10};
    tbl[2]  = '{1'b1, 18'h10, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 18'h10};
    tbl[3]  = '{1'b1, 18'h10, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 18'h10};
    tbl[4]  = '{1'b1, 18'h10, 1'b1, 1'b0, 32'h0,        1'b0, 8'h00, 1'b1, 18'h10};
    tbl[5]  = '{1'b1, 18'h10, 1'b0, 1'b1, 32'h44332211, 1'b0, 8'h00, 1'b0, 18'h0};
    tbl[6]  = '{1'b1, 18'h10, 1'b0, 1'b0, 32'h0,        1'b1, 8'h11, 1'b0, 18'h0};
    tbl[7]  = '{1'b1, 18'h13, 1'b0, 1'b0, 32'h0,        1'b1, 8'h44, 1'b0, 18'h0};
    tbl[8]  = '{1'b1, 18'h11, 1'b0, 1'b0, 32'h0,        1'b1, 8'h22, 1'b0, 18'h0};
    tbl[9]  = '{1'b1, 18'h14, 1'b0, 1'b0, 32'h0,        1'b0, 8'h11, 1'b0, 18'h0};
    tbl[10] = '{1'b1, 18'h14, 1'b1, 1'b0, 32'h0,        1'b0, 8'h11, 1'b1, 18'h14};
    tbl[11] = '{1'b1, 18'h14, 1'b0, 1'b1, 32'hDDCCBBAA, 1'b0, 8'h11, 1'b0, 18'h0};
    tbl[12] = '{1'b1, 18'h14, 1'b0, 1'b0, 32'h0,        1'b1, 8'hAA, 1'b0, 18'h0};
    tbl[13] = '{1'b1, 18'h12, 1'b0, 1'b0, 32'h0,        1'b1, 8'h33, 1'b0, 18'h0};
    tbl[14] = '{1'b0, 18'h12, 1'b0, 1'b0, 32'h0,        1'b0, 8'h33, 1'b0, 18'h0};

    // ---- reset state ----
    do_reset();
    #1;
    check("rst_req", req8, 1'b0);
    check("rst_saddr", saddr8, 18'h0);
    check("rst_ok", ok8, 1'b0);
    check("rst_dout", dout8, 8'h00);

    // ---- table ----
    for (int i = 0; i < 15; i++) begin
      idle_inputs();
      cs = tbl[i].cs; addr = tbl[i].addr;
      sdram_ack = tbl[i].ack;
      sdram_rdy = tbl[i].rdy; sdram_dst = tbl[i].rdy; din = tbl[i].din;
      #1;
      check($sformatf("tbl%0d_ok", i), ok8, tbl[i].exp_ok);
      check($sformatf("tbl%0d_dout", i), dout8, tbl[i].exp_dout);
      check($sformatf("tbl%0d_req", i), req8, tbl[i].exp_req);
      if (tbl[i].exp_req) check($sformatf("tbl%0d_saddr", i), saddr8, tbl[i].exp_saddr);
      step();
    end

    // ---- DW=16 ----
    do_reset();
    cs = 1'b1; addr = 18'h21;
    #1 check("dw16_miss_ok", ok16, 1'b0);
    step();
    check("dw16_req", req16, 1'b1);
    check("dw16_saddr", saddr16, 18'h20);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_rdy = 1'b1; din = 32'hBBBBAAAA;
    #1 check("dw16_rdy_ok", ok16, 1'b0);
    step();
    idle_inputs();
    #1;
    check("dw16_ok", ok16, 1'b1);
    check("dw16_dout_hi", dout16, 16'hBBBB);
    addr = 18'h20;
    #1 check("dw16_dout_lo", dout16, 16'hAAAA);

    // ---- round-robin ----
    do_reset();
    fetch8(18'h100, 32'hA3A2A1A0);
    #1 check("rr_a_ok", ok8, 1'b1);
    fetch8(18'h200, 32'hB3B2B1B0);
    fetch8(18'h300, 32'hC3C2C1C0);
    addr = 18'h201;
    #1;
    check("rr_b_hit", ok8, 1'b1);
    check("rr_b_dout", dout8, 8'hB1);
    step();
    check("rr_b_noreq", req8, 1'b0);
    addr = 18'h100;
    #1 check("rr_a_evicted", ok8, 1'b0);
    step();
    check("rr_a_req", req8, 1'b1);

    // ---- clr coincident with rdy ----
    do_reset();
    fetch8(18'h100, 32'hA3A2A1A0);
    cs = 1'b1; addr = 18'h200;
    step();
    check("clr_req", req8, 1'b1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_rdy = 1'b1; clr = 1'b1; din = 32'hEEEEEEEE;
    step();
    idle_inputs();
    addr = 18'h100;
    #1 check("clr_a_gone", ok8, 1'b0);
    addr = 18'h200;
    #1 check("clr_b_notwritten", ok8, 1'b0);
    step();
    check("clr_rerequest", req8, 1'b1);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_rdy = 1'b1; din = 32'hB3B2B1B0;
    step();
    idle_inputs();
    #1;
    check("clr_refill_ok", ok8, 1'b1);
    check("clr_refill_dout", dout8, 8'hB0);
    // victim stayed at entry 1, so entry 0 still holds the first line's data
    cs = 1'b0; addr = 18'h300;
    #1 check("clr_victim_kept", dout8, 8'hA0);

    // ---- address change mid-fetch ----
    do_reset();
    cs = 1'b1; addr = 18'h100;
    step();
    check("mid_req1", req8, 1'b1);
    check("mid_saddr1", saddr8, 18'h100);
    addr = 18'h200;
    #1 check("mid_ok_req", ok8, 1'b0);
    step();
    check("mid_saddr_held", saddr8, 18'h100);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0; sdram_dst = 1'b1; sdram_rdy = 1'b1; din = 32'h5A5A1234;
    #1 check("mid_ok_rdy", ok8, 1'b0);
    step();
    idle_inputs();
    #1;
    check("mid_ok_after1", ok8, 1'b0);
    check("mid_noreq_yet", req8, 1'b0);
    step();
    check("mid_req2", req8, 1'b1);
    check("mid_saddr2", saddr8, 18'h200);
    check("mid_ok_req2", ok8, 1'b0);
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    #1 check("mid_ok_wait2", ok8, 1'b0);
    sdram_dst = 1'b1; sdram_rdy = 1'b1; din = 32'hC0FFEE00;
    step();
    idle_inputs();
    #1;
    check("mid_ok_final", ok8, 1'b1);
    check("mid_dout_final", dout8, 8'h00);
    addr = 18'h100;
    #1 check("mid_first_line", dout8, 8'h34);

    // ---- reset mid-fetch ----
    do_reset();
    cs = 1'b1; addr = 18'h40;
    step();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rstmid_req", req8, 1'b0);
    check("rstmid_ok", ok8, 1'b0);
    cs = 1'b0;
    sdram_dst = 1'b1; sdram_rdy = 1'b1; din = 32'hFFFFFFFF;
    step();
    idle_inputs();
    cs = 1'b1;
    #1;
    check("rstmid_stray_ok", ok8, 1'b0);
    check("rstmid_stray_dout", dout8, 8'h00);
    check("rstmid_stray_req", req8, 1'b0);

    // ---- randomized run against the line-cache model ----
    bases = '{18'h0, 18'h4, 18'h100, 18'h104, 18'h3FFFC, 18'h20000};
    do_reset();
    for (int e = 0; e < 2; e++) begin
      m_valid[e] = 1'b0; m_tag[e] = '0; m_data[e] = '0;
    end
    m_vic = 1'b0; m_busy = 1'b0; m_discard = 1'b0; m_req = 1'b0; m_fill_tag = '0;
    exp_q.delete();
    c_st = 0; c_cnt = 0; prev_req = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      cs   = ($urandom_range(0, 3) != 0);
      addr = bases[$urandom_range(0, 5)] | 18'($urandom_range(0, 3));
      clr  = ($urandom_range(0, 39) == 0);
      // SDRAM controller stand-in
      fill_now = 1'b0;
      if (c_st == 0 && req8) begin
        c_st = 1; c_cnt = $urandom_range(0, 3);
      end
      if (c_st == 1) begin
        if (c_cnt == 0) begin
          sdram_ack = 1'b1; c_st = 2; c_cnt = $urandom_range(0, 4);
        end else c_cnt--;
      end else if (c_st == 2) begin
        if (c_cnt == 0) begin
          sdram_dst = 1'b1; sdram_rdy = 1'b1; din = $urandom; fill_now = 1'b1; c_st = 0;
        end else c_cnt--;
      end
      if (!fill_now && $urandom_range(0, 5) == 0) begin
        sdram_rdy = 1'b1; din = $urandom;
        sdram_dst = (c_st == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      #1;
      h0 = m_valid[0] && m_tag[0] == addr[AW-1:2];
      h1 = m_valid[1] && m_tag[1] == addr[AW-1:2];
      wd = (h1 && !h0) ? m_data[1] : m_data[0];
      e_dout = 8'(wd >> (8 * addr[1:0]));
      check("rnd_ok", ok8, cs && (h0 || h1));
      check("rnd_dout", dout8, e_dout);
      check("rnd_req", req8, m_req);
      if (req8 && !prev_req) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rnd_unexpected_req: got req at %0h, expected none", saddr8);
        end else check("rnd_saddr", saddr8, exp_q.pop_front());
      end
      prev_req = req8;
      // advance the model across the coming edge
      was_busy = m_busy;
      if (!m_busy && cs && !(h0 || h1)) begin
        m_busy = 1'b1; m_req = 1'b1; m_fill_tag = addr[AW-1:2];
        exp_q.push_back({addr[AW-1:2], 2'b00});
      end
      if (sdram_ack) m_req = 1'b0;
      if (fill_now) begin
        if (!m_discard && !clr) begin
          m_valid[m_vic] = 1'b1; m_tag[m_vic] = m_fill_tag; m_data[m_vic] = din;
          m_vic = ~m_vic;
        end
        m_busy = 1'b0; m_discard = 1'b0;
      end
      if (clr) begin
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        if (was_busy && !fill_now) m_discard = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Upper bound on total run time.
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
